// File: rtl/spike_rate_decoder.sv
// ----------------------------------------------------------------------------
// spike_rate_decoder
//
// Receive-side decoder for a single-bit spike train. It counts rising edges
// of spike_in over a window of WINDOW enabled cycles, and it tracks the most
// recent inter-spike interval (ISI) in enabled cycles. At each window close,
// both values go into one registered result that is handed downstream over a
// valid/ready handshake.
//
// Parameters
//   WINDOW  window length in enabled cycles (must be >= 2)
//   CNT_W   width of the spike-count result (saturating)
//   ISI_W   width of the ISI result (saturating)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   spike_in   in   spike train, level signal; one rising edge = one spike
//   enable     in   low freezes window, count and ISI timing
//   out_ready  in   downstream accepts the result this cycle
//   out_valid  out  result register holds an unconsumed result
//   rate       out  spike count of the last closed window
//   isi        out  last complete ISI, sampled at window close
//   overrun    out  sticky: an unconsumed result was overwritten
// ----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int WINDOW = 64,
    parameter int CNT_W  = 8,
    parameter int ISI_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike_in,
    input  logic             enable,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] rate,
    output logic [ISI_W-1:0] isi,
    output logic             overrun
);

    localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic             r_spike_prev;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_spk_cnt;
    logic [ISI_W-1:0] r_isi_cnt;
    logic [ISI_W-1:0] r_last_isi;
    logic             r_first_seen;

    logic             r_out_valid;
    logic [CNT_W-1:0] r_rate;
    logic [ISI_W-1:0] r_isi;
    logic             r_overrun;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             w_edge;
    logic             w_close;
    logic             w_xfer;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_close;
    logic [ISI_W-1:0] w_isi_inc;
    logic [ISI_W-1:0] w_last_isi_nxt;

    // An edge counts only on an enabled cycle. The edge history itself is
    // updated every cycle, so a level that rose while disabled does not
    // produce an edge once enable returns.
    assign w_edge  = enable & spike_in & ~r_spike_prev;
    assign w_close = enable && (r_win_cnt == WIN_LAST);
    assign w_xfer  = r_out_valid & out_ready;

    assign w_cnt_inc   = (r_spk_cnt == '1) ? r_spk_cnt : r_spk_cnt + 1'b1;
    // The value reported at close includes an edge that lands on the close cycle.
    assign w_cnt_close = w_edge ? w_cnt_inc : r_spk_cnt;

    assign w_isi_inc = (r_isi_cnt == '1) ? r_isi_cnt : r_isi_cnt + 1'b1;

    // An interval becomes valid only once a previous edge exists. The result
    // register samples this so that an ISI completed on the close cycle is
    // reported in the same window.
    assign w_last_isi_nxt = (w_edge && r_first_seen) ? r_isi_cnt : r_last_isi;

    // ------------------------------------------------------------------------
    // Edge history
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spike_prev <= 1'b0;
        end else begin
            r_spike_prev <= spike_in;
        end
    end

    // ------------------------------------------------------------------------
    // Window counter and spike count
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_spk_cnt <= '0;
        end else if (enable) begin
            if (w_close) begin
                r_win_cnt <= '0;
                // An edge on the close cycle also opens the next window's count.
                r_spk_cnt <= CNT_W'(w_edge);
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                if (w_edge) begin
                    r_spk_cnt <= w_cnt_inc;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Inter-spike interval
    // ------------------------------------------------------------------------
    // isi_cnt is set to 1 on an edge, so the counter reads k at an edge
    // k enabled cycles after the previous one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_isi_cnt    <= '0;
            r_last_isi   <= '0;
            r_first_seen <= 1'b0;
        end else if (w_edge) begin
            r_last_isi   <= w_last_isi_nxt;
            r_isi_cnt    <= ISI_W'(1);
            r_first_seen <= 1'b1;
        end else if (enable) begin
            r_isi_cnt <= w_isi_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Result register and handshake
    // ------------------------------------------------------------------------
    // A close always loads a new result. The case that overwrites is a close
    // while the old result is still pending and is not being taken this
    // cycle. A transfer clears overrun, including on a coincident close.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_rate      <= '0;
            r_isi       <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_close) begin
                r_out_valid <= 1'b1;
                r_rate      <= w_cnt_close;
                r_isi       <= w_last_isi_nxt;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_close && r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else if (w_xfer) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign rate      = r_rate;
    assign isi       = r_isi;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Directed bench for spike_rate_decoder. The u_dut instance uses the default
// parameters (64/8/8). The u_sat instance (1024/8/4) exercises saturation.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so they reflect the edge that just occurred. Cycle index c counts
// the clock edges after reset release, starting at 0.
// ----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, spike_in, enable, out_ready;
    logic       out_valid, overrun;
    logic [7:0] rate, isi;

    logic       s_reset, s_spike, s_enable, s_ready;
    logic       s_valid, s_ovr;
    logic [7:0] s_rate;
    logic [3:0] s_isi;

    int n_tests = 0;
    int n_fail  = 0;

    spike_rate_decoder #(.WINDOW(64), .CNT_W(8), .ISI_W(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .spike_in  (spike_in),
        .enable    (enable),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .rate      (rate),
        .isi       (isi),
        .overrun   (overrun)
    );

    spike_rate_decoder #(.WINDOW(1024), .CNT_W(8), .ISI_W(4)) u_sat (
        .clk       (clk),
        .reset     (s_reset),
        .spike_in  (s_spike),
        .enable    (s_enable),
        .out_ready (s_ready),
        .out_valid (s_valid),
        .rate      (s_rate),
        .isi       (s_isi),
        .overrun   (s_ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        spike_in  = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b0;
        s_reset   = 1'b1;
        s_spike   = 1'b0;
        s_enable  = 1'b1;
        s_ready   = 1'b1;

        // ---------------- reset state and first-result latency ----------------
        step();
        check("rst_valid", out_valid, 0);
        check("rst_rate",  rate,      0);
        check("rst_isi",   isi,       0);
        check("rst_ovr",   overrun,   0);
        do_reset();
        for (int c = 0; c < 70; c++) begin
            spike_in = (c == 10);
            step();
            if (c == 62) check("lat_valid_62", out_valid, 0);
            if (c == 63) check("lat_valid_63", out_valid, 1);
            if (c == 63) check("lat_rate",     rate,      1);
        end
        check("pre_async_valid", out_valid, 1);
        // Assert reset between edges: outputs must clear without a clock edge.
        reset = 1'b1;
        #2;
        check("async_valid", out_valid, 0);
        check("async_rate",  rate,      0);
        check("async_isi",   isi,       0);
        check("async_ovr",   overrun,   0);
        reset = 1'b0;
        for (int c = 0; c < 64; c++) begin
            spike_in = 1'b0;
            step();
            if (c == 62) check("rel_valid_62", out_valid, 0);
            if (c == 63) check("rel_valid_63", out_valid, 1);
        end

        // ---------------- periodic train: pulse every 8 cycles ---------------
        out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 192; c++) begin
            spike_in = ((c % 8) == 2);
            step();
            check("per_valid", out_valid, ((c % 64) == 63));
            if ((c % 64) == 63) begin
                check("per_rate", rate, 8);
                check("per_isi",  isi,  8);
            end
        end

        // ---------------- held level: 5-cycle high once per window ------------
        do_reset();
        for (int c = 0; c < 128; c++) begin
            spike_in = ((c % 64) >= 4) && ((c % 64) < 9);
            step();
            if (c == 63)  begin check("held_rate0", rate, 1); check("held_isi0", isi, 0);  end
            if (c == 127) begin check("held_rate1", rate, 1); check("held_isi1", isi, 64); end
        end

        // ---------------- backpressure, overrun, coincident close ------------
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 257; c++) begin
            spike_in  = (c == 10) || (c == 20) || (c == 30) ||
                        ((c >= 74) && (c <= 114) && ((c % 10) == 4)) ||
                        (c == 200) || (c == 210);
            out_ready = (c == 128) || (c == 255);
            step();
            if (c == 63) begin
                check("bp_valid0", out_valid, 1); check("bp_rate0", rate, 3);
                check("bp_ovr0",   overrun,   0); check("bp_isi0",  isi,  10);
            end
            if (c == 127) begin
                check("bp_valid1", out_valid, 1); check("bp_rate1", rate, 5);
                check("bp_ovr1",   overrun,   1); check("bp_isi1",  isi,  10);
            end
            if (c == 128) begin
                check("xfer_valid", out_valid, 0); check("xfer_ovr", overrun, 0);
            end
            if (c == 191) begin
                check("bp_valid2", out_valid, 1); check("bp_ovr2", overrun, 0);
                check("bp_rate2",  rate,      0);
            end
            if (c == 255) begin
                check("coin_valid", out_valid, 1); check("coin_ovr", overrun, 0);
                check("coin_rate",  rate,      2); check("coin_isi", isi,     10);
            end
            if (c == 256) check("coin_hold_valid", out_valid, 1);
        end

        // ---------------- enable gating ----------------
        out_ready = 1'b1;
        do_reset();
        for (int r = 0; r < 170; r++) begin
            int e;
            int d;
            if (r < 30) begin
                enable   = 1'b1;
                spike_in = (r == 5) || (r == 15) || (r == 25);
            end else if (r < 130) begin
                d        = r - 30;
                enable   = 1'b0;
                spike_in = (d < 96) ? ((d % 2) == 0) : (d >= 98);
            end else begin
                e        = r - 100;
                enable   = 1'b1;
                spike_in = (e == 30) || (e == 31) || (e == 40) || (e == 50);
            end
            step();
            check("gate_valid", out_valid, (r == 163));
            if (r == 163) begin
                check("gate_rate", rate, 5);
                check("gate_isi",  isi,  10);
            end
        end
        enable = 1'b1;

        // ---------------- saturation (1024 window, 4-bit ISI) ----------------
        s_reset = 1'b0;
        for (int c = 0; c < 2048; c++) begin
            if (c <= 1100) s_spike = ((c % 2) == 0);
            else           s_spike = (c == 1140);
            step();
            if (c == 1022) check("sat_valid_early", s_valid, 0);
            if (c == 1023) begin
                check("sat_valid0", s_valid, 1);
                check("sat_rate0",  s_rate,  255);
                check("sat_isi0",   s_isi,   2);
            end
            if (c == 2047) begin
                check("sat_valid1", s_valid, 1);
                check("sat_rate1",  s_rate,  40);
                check("sat_isi1",   s_isi,   15);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
